// File: rtl/icache_fetch_responder.sv
// Responder end of the fetch-side ICache interface: forwards 8-byte-aligned fetches to memory,
// returns 64-bit packets in order and drops packets that were in flight at a flush.
// Optional one-entry line buffer is enabled by defining FETCH_LINE_BUF_EN.
module icache_fetch_responder #(
    parameter int OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        icache_req,
    input  logic [31:0] icache_addr,
    output logic        icache_addr_ok,
    output logic        icache_data_ok,
    output logic [63:0] icache_rdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [63:0] mem_rdata,
    input  logic        fetch_buf_inval
);

    localparam int CNT_W = $clog2(OUTSTANDING) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   out_cnt_reg, out_cnt_next;
    logic [CNT_W-1:0]   discard_cnt_reg, discard_cnt_next;
    logic               rsp_valid_reg, rsp_valid_next;
    logic [63:0]        rsp_data_reg, rsp_data_next;
    logic               full, mem_accept, mem_rsp, rsp_load, buf_hit;
    logic [63:0]        buf_rdata;
    logic [2:0]         unused_addr_lsb;

    assign unused_addr_lsb = icache_addr[2:0];

    assign full           = (out_cnt_reg == CNT_W'(OUTSTANDING));
    assign mem_req        = icache_req && !full && !flush && !buf_hit;
    assign mem_addr       = {icache_addr[31:3], 3'b000};
    assign mem_accept     = mem_req && mem_addr_ok;
    assign icache_addr_ok = mem_accept || buf_hit;

    // A data beat with nothing outstanding is a protocol error and is ignored entirely.
    assign mem_rsp  = mem_data_ok && (out_cnt_reg != '0);
    // The beat arriving in the flush cycle belongs to a cancelled fetch, so it is dropped too.
    assign rsp_load = mem_rsp && (discard_cnt_reg == '0) && !flush;

    assign icache_data_ok = rsp_valid_reg && !flush;
    assign icache_rdata   = rsp_data_reg;

    always_comb begin
        out_cnt_next = out_cnt_reg;
        if (mem_accept && !mem_rsp) begin
            out_cnt_next = out_cnt_reg + CNT_W'(1);
        end else if (!mem_accept && mem_rsp) begin
            out_cnt_next = out_cnt_reg - CNT_W'(1);
        end
    end

    // Recomputing from out_cnt on every flush avoids double counting a repeated flush.
    always_comb begin
        discard_cnt_next = discard_cnt_reg;
        if (flush) begin
            discard_cnt_next = out_cnt_reg - CNT_W'(mem_rsp);
        end else if (mem_rsp && (discard_cnt_reg != '0)) begin
            discard_cnt_next = discard_cnt_reg - CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (out_cnt_next != '0) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (discard_cnt_next != '0) begin
                    state_next = DRAIN;
                end else if (out_cnt_next == '0) begin
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                if (discard_cnt_next == '0) begin
                    state_next = (out_cnt_next != '0) ? BUSY : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rsp_valid_next = rsp_load || buf_hit;
        rsp_data_next  = rsp_data_reg;
        if (rsp_load) begin
            rsp_data_next = mem_rdata;
        end else if (buf_hit) begin
            rsp_data_next = buf_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            out_cnt_reg     <= '0;
            discard_cnt_reg <= '0;
            rsp_valid_reg   <= 1'b0;
            rsp_data_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            out_cnt_reg     <= out_cnt_next;
            discard_cnt_reg <= discard_cnt_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_data_reg    <= rsp_data_next;
        end
    end

`ifdef FETCH_LINE_BUF_EN
    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

    logic [28:0]      tag_fifo [OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic             buf_valid_reg;
    logic [28:0]      buf_tag_reg;
    logic [63:0]      buf_data_reg;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(OUTSTANDING - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // Only an empty pipeline may be served from the buffer, so ordering is never disturbed.
    assign buf_hit   = icache_req && buf_valid_reg && (buf_tag_reg == icache_addr[31:3]) &&
                       (state_reg == IDLE) && !flush && !fetch_buf_inval;
    assign buf_rdata = buf_data_reg;

    always_ff @(posedge clk) begin
        if (mem_accept) begin
            tag_fifo[wr_ptr_reg] <= icache_addr[31:3];
        end
    end

    // Discarded beats still pop their tag so the FIFO stays aligned with memory order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            buf_valid_reg <= 1'b0;
            buf_tag_reg   <= '0;
            buf_data_reg  <= '0;
        end else begin
            if (mem_accept) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (mem_rsp) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            if (fetch_buf_inval) begin
                buf_valid_reg <= 1'b0;
            end else if (rsp_load) begin
                buf_valid_reg <= 1'b1;
                buf_tag_reg   <= tag_fifo[rd_ptr_reg];
                buf_data_reg  <= mem_rdata;
            end
        end
    end
`else
    logic unused_inval;

    assign buf_hit      = 1'b0;
    assign buf_rdata    = '0;
    assign unused_inval = fetch_buf_inval;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(mem_data_ok && (out_cnt_reg == '0)))
                else $warning("icache_fetch_responder: mem_data_ok with no outstanding fetch ignored");
        end
    end

endmodule
